axi4_burst_mem_slave: RTL and testbench

- AXI4-full slave backed by a word-addressed register memory.
- Sits directly downstream of the team's AXI4 burst master and terminates its AW/W/B and AR/R traffic.
- Supports INCR and FIXED bursts of 1-256 beats, 32-bit data, with byte strobes and ID echo.
- Write and read paths are independent FSMs sharing one storage array.

---
 rtl/axi4_pkg.sv | 30 +++
 rtl/axi4_burst_addr_gen.sv | 28 ++
 rtl/axi4_burst_mem_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_axi4_burst_mem_slave.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
`default_nettype none
//==============================================================================
// Package  : axi4_pkg
// Brief    : Shared AXI4 burst/response encodings and slave FSM state types.
// Revision : 1.0 - initial release
//==============================================================================
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_ADDR = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_ADDR = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage : axi4_pkg
`default_nettype wire

// File: rtl/axi4_burst_addr_gen.sv
`default_nettype none
//==============================================================================
// Module   : axi4_burst_addr_gen
// Brief    : Next beat address and beat legality (burst type + range) check.
// Revision : 1.0 - initial release
//==============================================================================
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_burst,
    output logic [31:0] o_next_addr,
    output logic        o_beat_ok
);

    // One bit wider than the address so DEPTH*4 never overflows the compare.
    localparam logic [32:0] c_LIMIT = 33'(DEPTH) * 33'd4;

    always_comb begin
        o_next_addr = (i_burst == BURST_INCR) ? (i_addr + 32'd4) : i_addr;
        o_beat_ok   = ((i_burst == BURST_FIXED) || (i_burst == BURST_INCR)) &&
                      ({1'b0, i_addr} < c_LIMIT);
    end

endmodule : axi4_burst_addr_gen
`default_nettype wire

// File: rtl/axi4_burst_mem_slave.sv
`default_nettype none
//==============================================================================
// Module   : axi4_burst_mem_slave
// Brief    : AXI4 slave with INCR/FIXED bursts over a word-addressed memory.
// Revision : 1.0 - initial release
//==============================================================================
module axi4_burst_mem_slave
    import axi4_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int ID_W  = 4
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    input  logic [ID_W-1:0] S_AXI_AWID,
    input  logic [31:0]     S_AXI_AWADDR,
    input  logic [7:0]      S_AXI_AWLEN,
    input  logic [1:0]      S_AXI_AWBURST,
    input  logic            S_AXI_AWVALID,
    output logic            S_AXI_AWREADY,
    input  logic [31:0]     S_AXI_WDATA,
    input  logic [3:0]      S_AXI_WSTRB,
    input  logic            S_AXI_WLAST,
    input  logic            S_AXI_WVALID,
    output logic            S_AXI_WREADY,
    output logic [ID_W-1:0] S_AXI_BID,
    output logic [1:0]      S_AXI_BRESP,
    output logic            S_AXI_BVALID,
    input  logic            S_AXI_BREADY,
    input  logic [ID_W-1:0] S_AXI_ARID,
    input  logic [31:0]     S_AXI_ARADDR,
    input  logic [7:0]      S_AXI_ARLEN,
    input  logic [1:0]      S_AXI_ARBURST,
    input  logic            S_AXI_ARVALID,
    output logic            S_AXI_ARREADY,
    output logic [ID_W-1:0] S_AXI_RID,
    output logic [31:0]     S_AXI_RDATA,
    output logic [1:0]      S_AXI_RRESP,
    output logic            S_AXI_RLAST,
    output logic            S_AXI_RVALID,
    input  logic            S_AXI_RREADY
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] r_mem [DEPTH];

    // ------------------------------------------------------------------ write
    wr_state_t       r_wstate, w_wstate_nxt;
    logic [31:0]     r_waddr;
    logic [7:0]      r_wlen, r_wcnt;
    logic [1:0]      r_wburst;
    logic [ID_W-1:0] r_bid;
    logic            r_werr;
    logic [31:0]     w_waddr_nxt;
    logic            w_wbeat_ok, w_aw_hs, w_w_hs, w_wlast_beat;
    logic [c_AW-1:0] w_widx;

    axi4_burst_addr_gen #(.DEPTH(DEPTH)) u_wgen (
        .i_addr      (r_waddr),
        .i_burst     (r_wburst),
        .o_next_addr (w_waddr_nxt),
        .o_beat_ok   (w_wbeat_ok)
    );

    assign w_aw_hs      = S_AXI_AWVALID && (r_wstate == W_ADDR);
    assign w_w_hs       = S_AXI_WVALID && (r_wstate == W_DATA);
    assign w_wlast_beat = (r_wcnt == r_wlen);
    assign w_widx       = r_waddr[c_AW+1:2];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_wstate <= W_ADDR;
        else          r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BRESP   = RESP_OKAY;
        case (r_wstate)
            W_ADDR: begin
                S_AXI_AWREADY = 1'b1;
                if (w_aw_hs) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                S_AXI_BRESP  = r_werr ? RESP_SLVERR : RESP_OKAY;
                if (S_AXI_BREADY) w_wstate_nxt = W_ADDR;
            end
            default: w_wstate_nxt = W_ADDR;
        endcase
    end

    assign S_AXI_BID = r_bid;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_wburst <= '0;
            r_bid    <= '0;
            r_werr   <= 1'b0;
        end else if (w_aw_hs) begin
            r_waddr  <= S_AXI_AWADDR;
            r_wlen   <= S_AXI_AWLEN;
            r_wcnt   <= '0;
            r_wburst <= S_AXI_AWBURST;
            r_bid    <= S_AXI_AWID;
            r_werr   <= 1'b0;
        end else if (w_w_hs) begin
            r_waddr <= w_waddr_nxt;
            r_wcnt  <= r_wcnt + 8'd1;
            // Sticky: bad beat or WLAST not lining up with the burst length.
            r_werr  <= r_werr || !w_wbeat_ok || (S_AXI_WLAST != w_wlast_beat);
        end
    end

    // Storage is deliberately unreset so a reset mid-burst keeps written beats.
    always_ff @(posedge ACLK) begin
        if (w_w_hs && w_wbeat_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) r_mem[w_widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------- read
    rd_state_t       r_rstate, w_rstate_nxt;
    logic [31:0]     r_raddr, r_rdata;
    logic [7:0]      r_rlen, r_rcnt;
    logic [1:0]      r_rburst, r_rresp;
    logic [ID_W-1:0] r_rid;
    logic            r_rlast;
    logic [31:0]     w_rsel_addr, w_raddr_nxt;
    logic [1:0]      w_rsel_burst;
    logic [7:0]      w_rsel_len, w_rnext_cnt;
    logic            w_rbeat_ok, w_ar_hs, w_r_hs, w_rfetch;
    logic [c_AW-1:0] w_ridx;

    assign w_ar_hs      = S_AXI_ARVALID && (r_rstate == R_ADDR);
    assign w_r_hs       = S_AXI_RREADY && (r_rstate == R_DATA);
    assign w_rfetch     = w_ar_hs || (w_r_hs && !r_rlast);
    // When idle the first beat is fetched straight from the AR channel.
    assign w_rsel_addr  = (r_rstate == R_ADDR) ? S_AXI_ARADDR  : r_raddr;
    assign w_rsel_burst = (r_rstate == R_ADDR) ? S_AXI_ARBURST : r_rburst;
    assign w_rsel_len   = (r_rstate == R_ADDR) ? S_AXI_ARLEN   : r_rlen;
    assign w_rnext_cnt  = (r_rstate == R_ADDR) ? 8'd0 : (r_rcnt + 8'd1);
    assign w_ridx       = w_rsel_addr[c_AW+1:2];

    axi4_burst_addr_gen #(.DEPTH(DEPTH)) u_rgen (
        .i_addr      (w_rsel_addr),
        .i_burst     (w_rsel_burst),
        .o_next_addr (w_raddr_nxt),
        .o_beat_ok   (w_rbeat_ok)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_rstate <= R_ADDR;
        else          r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt  = r_rstate;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (r_rstate)
            R_ADDR: begin
                S_AXI_ARREADY = 1'b1;
                if (w_ar_hs) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (w_r_hs && r_rlast) w_rstate_nxt = R_ADDR;
            end
            default: w_rstate_nxt = R_ADDR;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rburst <= '0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_rlast  <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_rlen   <= S_AXI_ARLEN;
                r_rburst <= S_AXI_ARBURST;
                r_rid    <= S_AXI_ARID;
            end
            if (w_rfetch) begin
                r_raddr <= w_raddr_nxt;
                r_rcnt  <= w_rnext_cnt;
                r_rlast <= (w_rnext_cnt == w_rsel_len);
                r_rdata <= w_rbeat_ok ? r_mem[w_ridx] : 32'd0;
                r_rresp <= w_rbeat_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (w_r_hs) begin
                r_rlast <= 1'b0;
            end
        end
    end

    assign S_AXI_RID   = r_rid;
    assign S_AXI_RDATA = r_rdata;
    assign S_AXI_RRESP = r_rresp;
    assign S_AXI_RLAST = r_rlast;

endmodule : axi4_burst_mem_slave
`default_nettype wire

// File: tb/tb_axi4_burst_mem_slave.sv
`default_nettype none
//==============================================================================
// Module   : tb_axi4_burst_mem_slave
// Brief    : Directed self-checking bench for axi4_burst_mem_slave.
// Revision : 1.0 - initial release
//==============================================================================
module tb_axi4_burst_mem_slave;

    localparam int DEPTH = 64;
    localparam int ID_W  = 4;

    logic            ACLK, ARESETn;
    logic [ID_W-1:0] S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
    logic [31:0]     S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
    logic [7:0]      S_AXI_AWLEN, S_AXI_ARLEN;
    logic [1:0]      S_AXI_AWBURST, S_AXI_BRESP, S_AXI_ARBURST, S_AXI_RRESP;
    logic [3:0]      S_AXI_WSTRB;
    logic            S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic            S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic            S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

    axi4_burst_mem_slave #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wr_data [256];
    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        else             n_pass++;
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [3:0] strb, input int early,
                             input int bstall, input logic [1:0] exp_resp);
        int g;
        @(negedge ACLK);
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWBURST = burst;
        S_AXI_AWVALID = 1'b1;
        g = 0;
        while (!S_AXI_AWREADY && g < 50) begin @(negedge ACLK); g++; end
        if (g >= 50) check_value("aw_timeout", 0, 1);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            S_AXI_WDATA = wr_data[i]; S_AXI_WSTRB = strb;
            S_AXI_WLAST = (i == early) || (i == int'(len));
            S_AXI_WVALID = 1'b1;
            g = 0;
            while (!S_AXI_WREADY && g < 50) begin @(negedge ACLK); g++; end
            if (g >= 50) check_value("w_timeout", 0, 1);
            @(negedge ACLK);
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        check_value("wready_drop", S_AXI_WREADY, 0);
        g = 0;
        while (!S_AXI_BVALID && g < 50) begin @(negedge ACLK); g++; end
        if (g >= 50) check_value("b_timeout", 0, 1);
        check_value("bresp", S_AXI_BRESP, exp_resp);
        check_value("bid", S_AXI_BID, id);
        for (int s = 0; s < bstall; s++) begin
            @(negedge ACLK);
            check_value("bvalid_hold", S_AXI_BVALID, 1);
            check_value("bid_hold", S_AXI_BID, id);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        check_value("bvalid_clr", S_AXI_BVALID, 0);
        check_value("awready_ret", S_AXI_AWREADY, 1);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit toggle);
        int g, n;
        bit stalled;
        logic [31:0] held;
        @(negedge ACLK);
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARBURST = burst;
        S_AXI_ARVALID = 1'b1;
        g = 0;
        while (!S_AXI_ARREADY && g < 50) begin @(negedge ACLK); g++; end
        if (g >= 50) check_value("ar_timeout", 0, 1);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        check_value("rvalid_n1", S_AXI_RVALID, 1);
        n = 0; g = 0; stalled = 0; held = '0;
        while (n <= int'(len) && g < 600) begin
            if (stalled) check_value("rdata_stall", S_AXI_RDATA, held);
            S_AXI_RREADY = toggle ? g[0] : 1'b1;
            stalled = 0;
            if (S_AXI_RVALID) begin
                if (S_AXI_RREADY) begin
                    rd_data[n] = S_AXI_RDATA;
                    rd_resp[n] = S_AXI_RRESP;
                    check_value("rid", S_AXI_RID, id);
                    check_value("rlast", S_AXI_RLAST, (n == int'(len)));
                    n++;
                end else begin
                    stalled = 1;
                    held = S_AXI_RDATA;
                end
            end
            @(negedge ACLK);
            g++;
        end
        if (g >= 600) check_value("r_timeout", 0, 1);
        S_AXI_RREADY = 1'b0;
        check_value("rvalid_clr", S_AXI_RVALID, 0);
    endtask

    initial begin
        ARESETn = 1'b0;
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWBURST = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        repeat (2) @(negedge ACLK);

        check_value("rst_awready", S_AXI_AWREADY, 1);
        check_value("rst_arready", S_AXI_ARREADY, 1);
        check_value("rst_wready", S_AXI_WREADY, 0);
        check_value("rst_bvalid", S_AXI_BVALID, 0);
        check_value("rst_rvalid", S_AXI_RVALID, 0);
        check_value("rst_rlast", S_AXI_RLAST, 0);
        check_value("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 0);
        check_value("rst_ids", {S_AXI_BID, S_AXI_RID}, 0);
        check_value("rst_rdata", S_AXI_RDATA, 0);
        ARESETn = 1'b1;
        @(negedge ACLK);

        // W before AW must not be accepted
        S_AXI_WVALID = 1'b1;
        @(negedge ACLK); check_value("w_before_aw", S_AXI_WREADY, 0);
        @(negedge ACLK); check_value("w_before_aw2", S_AXI_WREADY, 0);
        S_AXI_WVALID = 1'b0;

        // INCR write with B stalled, then plain and toggled reads
        for (int i = 0; i < 4; i++) wr_data[i] = 32'h1000_0000 + i;
        axi_write(4'd5, 32'h4, 8'd3, 2'b01, 4'hF, -1, 5, 2'b00);
        axi_read(4'd6, 32'h4, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_value("incr_rd", rd_data[i], 32'h1000_0000 + i);
            check_value("incr_resp", rd_resp[i], 2'b00);
        end
        axi_read(4'd9, 32'h4, 8'd3, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) check_value("toggle_rd", rd_data[i], 32'h1000_0000 + i);

        // byte strobes
        wr_data[0] = 32'h1122_3344;
        axi_write(4'd1, 32'h10, 8'd0, 2'b01, 4'hF, -1, 0, 2'b00);
        wr_data[0] = 32'hAABB_CCDD;
        axi_write(4'd2, 32'h10, 8'd0, 2'b01, 4'h5, -1, 0, 2'b00);
        axi_read(4'd2, 32'h10, 8'd0, 2'b01, 1'b0);
        check_value("strobe_rd", rd_data[0], 32'h11BB_33DD);

        // FIXED bursts
        wr_data[0] = 32'd1; wr_data[1] = 32'd2; wr_data[2] = 32'd3;
        axi_write(4'd3, 32'h8, 8'd2, 2'b00, 4'hF, -1, 0, 2'b00);
        axi_read(4'd3, 32'h8, 8'd1, 2'b01, 1'b0);
        check_value("fixed_w0", rd_data[0], 32'd3);
        check_value("fixed_w1", rd_data[1], 32'h1000_0002);
        axi_read(4'd4, 32'h8, 8'd1, 2'b00, 1'b0);
        check_value("fixed_r0", rd_data[0], 32'd3);
        check_value("fixed_r1", rd_data[1], 32'd3);

        // running off the end of memory
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hA0 + i;
        axi_write(4'd7, 32'hF8, 8'd3, 2'b01, 4'hF, -1, 0, 2'b10);
        axi_read(4'd7, 32'hF8, 8'd3, 2'b01, 1'b0);
        check_value("oor_d0", rd_data[0], 32'hA0);
        check_value("oor_d1", rd_data[1], 32'hA1);
        check_value("oor_d2", rd_data[2], 32'h0);
        check_value("oor_d3", rd_data[3], 32'h0);
        check_value("oor_r", {rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}, 8'b00_00_10_10);

        // early WLAST
        for (int i = 0; i < 4; i++) wr_data[i] = 32'h50 + i;
        axi_write(4'd8, 32'h40, 8'd3, 2'b01, 4'hF, 1, 0, 2'b10);
        axi_read(4'd8, 32'h40, 8'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) check_value("early_rd", rd_data[i], 32'h50 + i);

        // unsupported read burst
        axi_read(4'd10, 32'h4, 8'd0, 2'b10, 1'b0);
        check_value("wrap_rdata", rd_data[0], 32'h0);
        check_value("wrap_rresp", rd_resp[0], 2'b10);

        // reset in the middle of a read burst
        @(negedge ACLK);
        S_AXI_ARID = 4'd3; S_AXI_ARADDR = 32'h4; S_AXI_ARLEN = 8'd7; S_AXI_ARBURST = 2'b01;
        S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
        repeat (2) @(negedge ACLK);
        check_value("mid_rvalid", S_AXI_RVALID, 1);
        ARESETn = 1'b0;
        #1;
        check_value("rst_mid_rvalid", S_AXI_RVALID, 0);
        check_value("rst_mid_arready", S_AXI_ARREADY, 1);
        check_value("rst_mid_rlast", S_AXI_RLAST, 0);
        @(negedge ACLK);
        ARESETn = 1'b1; S_AXI_RREADY = 1'b0;
        axi_read(4'd11, 32'h10, 8'd0, 2'b01, 1'b0);
        check_value("post_rst_rd", rd_data[0], 32'h11BB_33DD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_axi4_burst_mem_slave
`default_nettype wire
